// File: rtl/pc_next_unit.sv
// Fetch-stage PC register with next-PC selection, stall-time redirect capture
// and a circular return-address stack.
module pc_next_unit #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_PC  = '0,
    parameter int unsigned       INC       = 4,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             RedirectValid,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] BranchBase,
    input  logic [WIDTH-1:0] BranchOffset,
    input  logic [WIDTH-1:0] RegTarget,
    input  logic [WIDTH-1:0] JAddress,
    input  logic             Push,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlusInc,
    output logic             RasEmpty,
    output logic             RasUnderflow,
    output logic             PendValid
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    localparam logic [1:0] MODE_BRANCH = 2'd0;
    localparam logic [1:0] MODE_REG    = 2'd1;
    localparam logic [1:0] MODE_JUMP   = 2'd2;
    localparam logic [1:0] MODE_RET    = 2'd3;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_sp;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] mem_idx;
    logic [CNT_W-1:0] ras_cnt;
    logic [WIDTH-1:0] pend_target;
    logic [WIDTH-1:0] target;
    logic             pop;
    logic             pop_ok;
    logic             push_en;

    // Redirect target and RAS control decode
    always_comb begin
        PCPlusInc = PC + WIDTH'(INC);
        RasEmpty  = (ras_cnt == '0);
        top_idx   = ras_sp - PTR_W'(1);
        pop       = RedirectValid && (Mode == MODE_RET);
        pop_ok    = pop && !RasEmpty;
        push_en   = Push && !Stall;
        // A same-cycle push and pop rewrites the slot just popped
        mem_idx   = pop_ok ? top_idx : ras_sp;
        target    = RegTarget;
        case (Mode)
            MODE_BRANCH: target = BranchBase + (BranchOffset << 2);
            MODE_REG:    target = RegTarget;
            MODE_JUMP:   target = JAddress;
            MODE_RET:    target = RasEmpty ? RegTarget : ras_mem[top_idx];
            default:     target = RegTarget;
        endcase
    end

    // PC register and pending-redirect capture
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC          <= RESET_PC;
            PendValid   <= 1'b0;
            pend_target <= '0;
        end else if (Stall) begin
            if (RedirectValid) begin
                pend_target <= target;
                PendValid   <= 1'b1;
            end
        end else begin
            PendValid <= 1'b0;
            if (RedirectValid) begin
                PC <= target;
            end else if (PendValid) begin
                PC <= pend_target;
            end else begin
                PC <= PCPlusInc;
            end
        end
    end

    // RAS pointer, occupancy and underflow pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ras_sp       <= '0;
            ras_cnt      <= '0;
            RasUnderflow <= 1'b0;
        end else begin
            RasUnderflow <= pop && RasEmpty;
            if (push_en && pop_ok) begin
                ras_sp  <= ras_sp;
            end else if (push_en) begin
                ras_sp <= ras_sp + PTR_W'(1);
                if (ras_cnt != CNT_MAX) begin
                    ras_cnt <= ras_cnt + CNT_W'(1);
                end
            end else if (pop_ok) begin
                ras_sp  <= top_idx;
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

    // RAS storage; a full-stack push lands on the oldest entry
    always_ff @(posedge Clk) begin
        if (!Reset && push_en) begin
            ras_mem[mem_idx] <= PCPlusInc;
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed table-driven bench for pc_next_unit with RESET_PC = 0x00400000.
module tb_pc_next_unit;

    localparam int unsigned W = 32;

    logic         Clk;
    logic         Reset;
    logic         Stall;
    logic         RedirectValid;
    logic [1:0]   Mode;
    logic [W-1:0] BranchBase;
    logic [W-1:0] BranchOffset;
    logic [W-1:0] RegTarget;
    logic [W-1:0] JAddress;
    logic         Push;
    logic [W-1:0] PC;
    logic [W-1:0] PCPlusInc;
    logic         RasEmpty;
    logic         RasUnderflow;
    logic         PendValid;

    int errors = 0;
    int checks = 0;

    pc_next_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0040_0000),
        .INC      (4),
        .RAS_DEPTH(4)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .RedirectValid(RedirectValid),
        .Mode         (Mode),
        .BranchBase   (BranchBase),
        .BranchOffset (BranchOffset),
        .RegTarget    (RegTarget),
        .JAddress     (JAddress),
        .Push         (Push),
        .PC           (PC),
        .PCPlusInc    (PCPlusInc),
        .RasEmpty     (RasEmpty),
        .RasUnderflow (RasUnderflow),
        .PendValid    (PendValid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic         rst;
        logic         stall;
        logic         rv;
        logic [1:0]   mode;
        logic [W-1:0] bbase;
        logic [W-1:0] boff;
        logic [W-1:0] rtgt;
        logic [W-1:0] jaddr;
        logic         push;
        logic [W-1:0] exp_pc;
        logic         exp_pv;
        logic         exp_empty;
        logic         exp_uf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic stall, input logic rv,
                                input logic [1:0] mode, input logic [W-1:0] bbase,
                                input logic [W-1:0] boff, input logic [W-1:0] rtgt,
                                input logic [W-1:0] jaddr, input logic push,
                                input logic [W-1:0] exp_pc, input logic exp_pv,
                                input logic exp_empty, input logic exp_uf);
        vec_t v;
        v.rst = rst; v.stall = stall; v.rv = rv; v.mode = mode;
        v.bbase = bbase; v.boff = boff; v.rtgt = rtgt; v.jaddr = jaddr;
        v.push = push; v.exp_pc = exp_pc; v.exp_pv = exp_pv;
        v.exp_empty = exp_empty; v.exp_uf = exp_uf;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Reset         = v.rst;
        Stall         = v.stall;
        RedirectValid = v.rv;
        Mode          = v.mode;
        BranchBase    = v.bbase;
        BranchOffset  = v.boff;
        RegTarget     = v.rtgt;
        JAddress      = v.jaddr;
        Push          = v.push;
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // reset and sequential increment
        vecs.push_back(mk(1,0,0,0, 0,0,0,0, 0, 32'h0040_0000,0,1,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 32'h0040_0004,0,1,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 32'h0040_0008,0,1,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 32'h0040_000C,0,1,0));
        // branches, including wrap modulo 2^32
        vecs.push_back(mk(0,0,1,0, 32'h100,32'hFFFF_FFFE,0,0, 0, 32'h0000_00F8,0,1,0));
        vecs.push_back(mk(0,0,1,0, 32'h4,32'h7FFF_FFFF,0,0, 0, 32'h0000_0000,0,1,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 32'h0000_0004,0,1,0));
        // stall with two redirects, newest wins
        vecs.push_back(mk(0,1,1,2, 0,0,0,32'h2000, 0, 32'h0000_0004,1,1,0));
        vecs.push_back(mk(0,1,1,1, 0,0,32'h3000,0, 0, 32'h0000_0004,1,1,0));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0, 0, 32'h0000_0004,1,1,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 32'h0000_3000,0,1,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 32'h0000_3004,0,1,0));
        // fresh redirect on release beats pending
        vecs.push_back(mk(0,1,1,1, 0,0,32'h3000,0, 0, 32'h0000_3004,1,1,0));
        vecs.push_back(mk(0,0,1,2, 0,0,0,32'h5000, 0, 32'h0000_5000,0,1,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 32'h0000_5004,0,1,0));
        // five calls: A=5008 B=10004 C=20004 D=30004 E=40004
        vecs.push_back(mk(0,0,1,2, 0,0,0,32'h1_0000, 1, 32'h0001_0000,0,0,0));
        vecs.push_back(mk(0,0,1,2, 0,0,0,32'h2_0000, 1, 32'h0002_0000,0,0,0));
        vecs.push_back(mk(0,0,1,2, 0,0,0,32'h3_0000, 1, 32'h0003_0000,0,0,0));
        vecs.push_back(mk(0,0,1,2, 0,0,0,32'h4_0000, 1, 32'h0004_0000,0,0,0));
        vecs.push_back(mk(0,0,1,2, 0,0,0,32'h5_0000, 1, 32'h0005_0000,0,0,0));
        // five returns: E, D, C, B, then empty fallback
        vecs.push_back(mk(0,0,1,3, 0,0,32'hDEAD0,0, 0, 32'h0004_0004,0,0,0));
        vecs.push_back(mk(0,0,1,3, 0,0,32'hDEAD0,0, 0, 32'h0003_0004,0,0,0));
        vecs.push_back(mk(0,0,1,3, 0,0,32'hDEAD0,0, 0, 32'h0002_0004,0,0,0));
        vecs.push_back(mk(0,0,1,3, 0,0,32'hDEAD0,0, 0, 32'h0001_0004,0,1,0));
        vecs.push_back(mk(0,0,1,3, 0,0,32'hBEE0,0, 0, 32'h0000_BEE0,0,1,1));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 32'h0000_BEE4,0,1,0));
        // push and pop in one cycle
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1, 32'h0000_BEE8,0,0,0));
        vecs.push_back(mk(0,0,1,3, 0,0,32'hDEAD0,0, 1, 32'h0000_BEE8,0,0,0));
        vecs.push_back(mk(0,0,1,3, 0,0,32'hDEAD0,0, 0, 32'h0000_BEEC,0,1,0));
        // three pushes, pop during stall, then reset mid-pending
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1, 32'h0000_BEF0,0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1, 32'h0000_BEF4,0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1, 32'h0000_BEF8,0,0,0));
        vecs.push_back(mk(0,1,1,3, 0,0,32'hDEAD0,0, 0, 32'h0000_BEF8,1,0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0,0, 0, 32'h0040_0000,0,1,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0, 32'h0040_0004,0,1,0));

        drive(vecs[0]);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            tick();
            chk("pc",        i, PC,                   vecs[i].exp_pc);
            chk("pendvalid", i, W'(PendValid),        W'(vecs[i].exp_pv));
            chk("rasempty",  i, W'(RasEmpty),         W'(vecs[i].exp_empty));
            chk("underflow", i, W'(RasUnderflow),     W'(vecs[i].exp_uf));
        end

        // push is suppressed while stalled; PCPlusInc follows PC
        chk("pcplusinc", 100, PCPlusInc, 32'h0040_0008);
        Stall = 1'b1; Push = 1'b1;
        tick();
        chk("stall_pc",    101, PC,           32'h0040_0004);
        chk("stall_empty", 101, W'(RasEmpty), W'(1'b1));
        Stall = 1'b0; Push = 1'b0;
        tick();
        chk("release_pc",  102, PC,           32'h0040_0008);
        chk("release_inc", 102, PCPlusInc,    32'h0040_000C);

        // empty return captured during stall: pulse once, fallback delivered on release
        Stall = 1'b1; RedirectValid = 1'b1; Mode = 2'd3; RegTarget = 32'h0000_7770;
        tick();
        chk("stall_uf",    103, W'(RasUnderflow), W'(1'b1));
        chk("stall_pv",    103, W'(PendValid),    W'(1'b1));
        RedirectValid = 1'b0;
        tick();
        chk("uf_clear",    104, W'(RasUnderflow), W'(1'b0));
        chk("held_pc",     104, PC,               32'h0040_0008);
        Stall = 1'b0;
        tick();
        chk("pend_ret_pc", 105, PC,               32'h0000_7770);
        chk("pend_clear",  105, W'(PendValid),    W'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
